// File: rtl/mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// mem_loader_pkg
// Shared definitions for the backdoor memory loader:
//   state_e      - parser state encoding (address, length, data, done)
//   HDR_BYTES    - header length in bytes (base address + word count)
//   WORD_BYTES   - bytes per memory word
//   FIELD_BYTES  - bytes per 32-bit field (base, count or data word)
// ---------------------------------------------------------------------------
package mem_loader_pkg;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int HDR_BYTES   = 8;
  localparam int WORD_BYTES  = 4;
  localparam int FIELD_BYTES = HDR_BYTES / 2;

endpackage

// File: rtl/mem_backdoor_loader_if.sv
// ---------------------------------------------------------------------------
// mem_backdoor_loader_if
// Byte-stream handshake feeding the loader (UART receiver / debug host side).
//   s_valid - source has a byte
//   s_data  - the byte
//   s_ready - loader accepts the byte this cycle
// Modports: master = byte source, slave = loader.
// ---------------------------------------------------------------------------
interface mem_backdoor_loader_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/mem_backdoor_loader.sv
// ---------------------------------------------------------------------------
// mem_backdoor_loader
// Parses a little-endian byte stream {base[31:0], count[31:0], data words}
// and writes each assembled 32-bit word to memory through the backdoor port,
// one single-cycle strobe per word at auto-incrementing word addresses.
//
// Ports:
//   ACLK, ARESETn   - clock, asynchronous active-low reset
//   s_if (slave)    - byte stream handshake (s_valid/s_data/s_ready)
//   load_abort      - synchronous abort back to header parsing
//   wr_mem_en       - backdoor write strobe (one cycle per word)
//   wr_mem_addr     - word-aligned byte address of the write
//   wr_mem_data     - word to write
//   load_busy       - load in progress (first header byte until load_done)
//   load_done       - one-cycle pulse when a load completes
//   load_err        - sticky misaligned-base flag
// ---------------------------------------------------------------------------
module mem_backdoor_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  mem_backdoor_loader_if.slave  s_if,
  input  logic                  load_abort,
  output logic                  wr_mem_en,
  output logic [ADDR_WIDTH-1:0] wr_mem_addr,
  output logic [DATA_WIDTH-1:0] wr_mem_data,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [1:0] LAST_BYTE = 2'(FIELD_BYTES - 1);

  state_e                state_q, state_d;
  logic [1:0]            bcnt_q, bcnt_d;
  // Holds the three earlier bytes of the field being collected; the fourth
  // byte arrives on s_data, so a complete field is {s_data, shift_q}. The
  // same assembler serves base address, word count and data words.
  logic [23:0]           shift_q, shift_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [31:0]           remaining_q, remaining_d;
  logic                  s_ready_q, s_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [31:0]           field;

  assign accept = s_if.s_valid & s_ready_q;
  assign field  = {s_if.s_data, shift_q};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= S_ADDR;
      bcnt_q      <= 2'd0;
      shift_q     <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      s_ready_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      s_ready_q   <= s_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;

    if (load_abort) begin
      // Abort wins over any byte accepted this cycle: the partial field is
      // dropped and no write or done pulse is produced.
      state_d = S_ADDR;
      bcnt_d  = 2'd0;
      shift_d = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (accept) begin
            shift_d = field[31:8];
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == 2'd0) begin
              busy_d = 1'b1;
              err_d  = 1'b0;
            end
            if (bcnt_q == LAST_BYTE) begin
              // A misaligned base is flagged but loading continues from the
              // word boundary below it.
              err_d   = (field[1:0] != 2'b00);
              ptr_d   = ADDR_WIDTH'(field) & ~ADDR_WIDTH'(WORD_BYTES - 1);
              state_d = S_LEN;
            end
          end
        end

        S_LEN: begin
          if (accept) begin
            shift_d = field[31:8];
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == LAST_BYTE) begin
              remaining_d = field;
              state_d     = (field == 32'd0) ? S_DONE : S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            shift_d = field[31:8];
            bcnt_d  = bcnt_q + 2'd1;
            if (bcnt_q == LAST_BYTE) begin
              wr_en_d     = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = DATA_WIDTH'(field);
              ptr_d       = ptr_q + ADDR_WIDTH'(WORD_BYTES);
              remaining_d = remaining_q - 32'd1;
              if (remaining_q == 32'd1) begin
                state_d = S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          // load_done is registered so it lands one cycle after the final
          // write strobe; busy drops on the same edge.
          state_d = S_ADDR;
          bcnt_d  = 2'd0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end

        default: begin
          state_d = S_ADDR;
          bcnt_d  = 2'd0;
        end
      endcase
    end

    // Ready is registered from the next state so it is low exactly while
    // the parser sits in S_DONE (and while in reset).
    s_ready_d = (state_d != S_DONE);
  end

  assign s_if.s_ready = s_ready_q;
  assign wr_mem_en    = wr_en_q;
  assign wr_mem_addr  = wr_addr_q;
  assign wr_mem_data  = wr_data_q;
  assign load_busy    = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule

// File: tb/tb_mem_backdoor_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_backdoor_loader
// Directed and randomized loads against a reference model that derives the
// expected writes, their timing and load_done from the stream format.
// ---------------------------------------------------------------------------
module tb_mem_backdoor_loader;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic        load_abort = 1'b0;
  logic        wr_mem_en;
  logic [31:0] wr_mem_addr;
  logic [31:0] wr_mem_data;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  mem_backdoor_loader_if s_if ();

  mem_backdoor_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .s_if       (s_if),
    .load_abort (load_abort),
    .wr_mem_en  (wr_mem_en),
    .wr_mem_addr(wr_mem_addr),
    .wr_mem_data(wr_mem_data),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  int unsigned cyc = 0;
  wr_t         got_wr[$];
  wr_t         exp_wr[$];
  int unsigned got_done[$];

  int vectors     = 0;
  int miscompares = 0;

  // Observe outputs on the falling edge, stamping each with a cycle index.
  always @(negedge ACLK) begin
    cyc++;
    if (wr_mem_en === 1'b1)
      got_wr.push_back('{addr: wr_mem_addr, data: wr_mem_data, cyc: cyc});
    if (load_done === 1'b1)
      got_done.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte, wait (bounded) for ready, return the cycle index at
  // which anything caused by this byte's acceptance first becomes visible.
  task automatic send_byte(input logic [7:0] b, input bit gap, output int unsigned acc);
    int waitc;
    waitc = 0;
    @(negedge ACLK);
    if (gap) begin
      s_if.s_valid = 1'b0;
      @(negedge ACLK);
    end
    s_if.s_valid = 1'b1;
    s_if.s_data  = b;
    while (s_if.s_ready !== 1'b1) begin
      waitc++;
      if (waitc > 20) begin
        chk("ready_timeout", 32'(s_if.s_ready), 32'd1);
        break;
      end
      @(negedge ACLK);
    end
    @(posedge ACLK);
    #1;
    acc = cyc + 1;
    s_if.s_valid = 1'b0;
  endtask

  // gapmode: 0 back-to-back, 1 idle cycle before every byte, 2 random gaps.
  // abort_after < 0 runs to completion; otherwise abort after that many bytes.
  task automatic run_load(input logic [31:0] base, input int n, input logic [7:0] dat[$],
                          input int gapmode, input int abort_after, input string tag);
    logic [7:0]  stream[$];
    logic [31:0] nn;
    logic [31:0] ptr;
    int unsigned acc;
    int unsigned last_acc;
    int          total;
    bit          gap;

    got_wr.delete();
    got_done.delete();
    exp_wr.delete();
    nn = 32'(n);
    for (int i = 0; i < 4; i++) stream.push_back(base[8*i +: 8]);
    for (int i = 0; i < 4; i++) stream.push_back(nn[8*i +: 8]);
    for (int i = 0; i < dat.size(); i++) stream.push_back(dat[i]);
    total    = (abort_after >= 0) ? abort_after : stream.size();
    ptr      = base & ~32'h3;
    last_acc = 0;

    for (int i = 0; i < total; i++) begin
      gap = (gapmode == 1) ? 1'b1 : (gapmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      send_byte(stream[i], gap, acc);
      if (i == 0) chk($sformatf("%s_busy_rise", tag), 32'(load_busy), 32'd1);
      if (i >= 8 && ((i - 8) % 4) == 3) begin
        exp_wr.push_back('{addr: ptr,
                           data: {stream[i], stream[i-1], stream[i-2], stream[i-3]},
                           cyc: acc});
        ptr = ptr + 32'd4;
      end
      last_acc = acc;
    end

    if (abort_after >= 0) begin
      @(negedge ACLK);
      load_abort = 1'b1;
      @(posedge ACLK);
      #1;
      load_abort = 1'b0;
      chk($sformatf("%s_abort_busy", tag), 32'(load_busy), 32'd0);
      chk($sformatf("%s_abort_ready", tag), 32'(s_if.s_ready), 32'd1);
    end else begin
      chk($sformatf("%s_done_ready", tag), 32'(s_if.s_ready), 32'd0);
      chk($sformatf("%s_done_busy", tag), 32'(load_busy), 32'd1);
    end

    repeat (4) @(negedge ACLK);
    #1;
    chk($sformatf("%s_nwr", tag), 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), got_wr[i].addr, exp_wr[i].addr);
      chk($sformatf("%s_wr%0d_data", tag, i), got_wr[i].data, exp_wr[i].data);
      chk($sformatf("%s_wr%0d_cyc", tag, i), got_wr[i].cyc, exp_wr[i].cyc);
    end
    if (abort_after >= 0) begin
      chk($sformatf("%s_ndone", tag), 32'(got_done.size()), 32'd0);
    end else begin
      chk($sformatf("%s_ndone", tag), 32'(got_done.size()), 32'd1);
      if (got_done.size() == 1)
        chk($sformatf("%s_done_cyc", tag), got_done[0], last_acc + 1);
    end
    chk($sformatf("%s_err", tag), 32'(load_err), 32'(base[1:0] != 2'b00));
    chk($sformatf("%s_end_busy", tag), 32'(load_busy), 32'd0);
    $display("load %s base=%h n=%0d writes=%0d", tag, base, n, got_wr.size());
  endtask

  logic [7:0]  d[$];
  logic [7:0]  rs[$];
  logic [31:0] rbase;
  int          rn;
  int          rab;
  int unsigned acc0;

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = 8'h00;
    #2 ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_ready", 32'(s_if.s_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_mem_en), 32'd0);
    chk("rst_addr", wr_mem_addr, 32'd0);
    chk("rst_data", wr_mem_data, 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    chk("rst_ready_rise", 32'(s_if.s_ready), 32'd1);

    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(32'h0000_0100, 2, d, 0, -1, "b2b");
    run_load(32'h0000_0100, 2, d, 1, -1, "gapped");

    d.delete();
    run_load(32'h0000_0040, 0, d, 0, -1, "n0");

    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(32'h0000_0103, 1, d, 0, -1, "misalign");

    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(32'h0000_0300, 1, d, 0, 10, "abort");
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(32'h0000_0200, 1, d, 0, -1, "fresh");

    d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    run_load(32'hFFFF_FFFC, 2, d, 0, -1, "wrap");

    // Reset mid-word: 8 header bytes (base 0x500, N=2) plus 2 data bytes.
    rs = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h99, 8'h98};
    got_wr.delete();
    for (int i = 0; i < rs.size(); i++) send_byte(rs[i], 1'b0, acc0);
    @(negedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    chk("arst_ready", 32'(s_if.s_ready), 32'd0);
    chk("arst_wr_en", 32'(wr_mem_en), 32'd0);
    chk("arst_addr", wr_mem_addr, 32'd0);
    chk("arst_data", wr_mem_data, 32'd0);
    chk("arst_busy", 32'(load_busy), 32'd0);
    chk("arst_done", 32'(load_done), 32'd0);
    chk("arst_err", 32'(load_err), 32'd0);
    chk("arst_nowrite", 32'(got_wr.size()), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    d = '{8'h5A, 8'h6B, 8'h7C, 8'h8D, 8'h12, 8'h34, 8'h56, 8'h78};
    run_load(32'h0000_0600, 2, d, 0, -1, "post_rst");

    for (int r = 0; r < 8; r++) begin
      rbase = $urandom;
      rn    = $urandom_range(0, 4);
      d.delete();
      for (int k = 0; k < 4 * rn; k++) d.push_back(8'($urandom));
      rab = -1;
      if (rn > 0 && $urandom_range(0, 2) == 0) rab = $urandom_range(8, 8 + 4 * rn - 1);
      run_load(rbase, rn, d, 2, rab, $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_backdoor_loader.md
# mem_backdoor_loader

Byte-stream loader that fills main memory through the `memory` block's backdoor write port (`wr_mem_en`/`wr_mem_addr`/`wr_mem_data`) before or between program runs. It sits directly upstream of `memory` and is typically fed by a UART receiver or a debug host. It parses a little-endian header (base address, word count), assembles 32-bit words from bytes, and issues one single-cycle write per word at auto-incrementing word addresses.

## Interface
- `DATA_WIDTH`, 32, width of memory words; fixed at 32 (4 bytes per word).
- `ADDR_WIDTH`, 32, width of the byte address on `wr_mem_addr`.
- `ACLK` in 1: the single clock.
- `ARESETn` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: input byte valid.
- `s_data` in 8: input byte.
- `s_ready` out 1: loader accepts a byte this cycle.
- `load_abort` in 1: synchronous abort; returns the loader to header parsing.
- `wr_mem_en` out 1: backdoor write strobe, one cycle per word.
- `wr_mem_addr` out ADDR_WIDTH: byte address of the word; bits [1:0] are always 0.
- `wr_mem_data` out DATA_WIDTH: word to write.
- `load_busy` out 1: high from the first accepted header byte until `load_done`. The system holds AXI masters off while it is high, because `memory` ORs the backdoor and AXI write ports.
- `load_done` out 1: one-cycle pulse when a load completes.
- `load_err` out 1: sticky misaligned-base flag; cleared by the next accepted first header byte or by reset.

## Operation
- A byte is accepted when `s_valid & s_ready`.
- Stream format:
  - 4 bytes base address, LSB first.
  - 4 bytes word count N, LSB first.
  - N×4 data bytes; each word is LSB first.
- States: `S_ADDR`, `S_LEN`, `S_DATA`, `S_DONE`.
  - A 2-bit byte counter `bcnt` steps through bytes 0..3 within each field.
  - A 32-bit `remaining` counter tracks words left to load.
- `S_ADDR`:
  - Shift each byte into `base[8*bcnt +: 8]`.
  - On byte 3, go to `S_LEN`.
  - If the base address is misaligned, set `load_err` and force address bits [1:0] to 0; loading continues.
- `S_LEN`:
  - Collect N into `remaining`.
  - On byte 3: if N==0, go to `S_DONE`; otherwise go to `S_DATA`.
- `S_DATA`:
  - Collect bytes into `word`.
  - On byte 3, register the output: `wr_mem_en`=1, `wr_mem_data`=assembled word, `wr_mem_addr`=current pointer.
  - Then pointer += 4 (wraps modulo 2^ADDR_WIDTH) and `remaining` -= 1.
  - If `remaining` was 1, go to `S_DONE`.
- `S_DONE`: lasts one cycle. `s_ready`=0, `load_done`=1, `load_busy` drops. Next state is `S_ADDR`.
- `load_abort`:
  - Takes priority over everything else.
  - Next cycle: `S_ADDR`, `bcnt`=0, partial word discarded, `load_busy`=0.
  - No `load_done` pulse.
  - A write already registered in the same cycle still completes.
- Partial words never reach memory.

## Timing
- Reset values:
  - `s_ready`=0 while `ARESETn` is low; it becomes 1 on the first clock edge after reset deassertion.
  - `wr_mem_en`=0, `wr_mem_addr`=0, `wr_mem_data`=0.
  - `load_busy`=0, `load_done`=0, `load_err`=0.
  - State=`S_ADDR`.
- `s_ready`=1 in `S_ADDR`, `S_LEN` and `S_DATA`; 0 only in `S_DONE`. Sustained throughput is 1 byte/cycle.
- Write latency: `wr_mem_en` is asserted exactly one cycle after the 4th byte of a word is accepted. It is high for exactly one cycle.
- `wr_mem_addr` and `wr_mem_data` are registered and only meaningful while `wr_mem_en`=1. They hold their last values otherwise.
- `load_done` is asserted the cycle after the last `wr_mem_en`. For N==0, it is asserted the cycle after the 8th header byte.
- `load_busy` rises the cycle after the first header byte is accepted.
- Gaps in `s_valid` stall parsing without any state loss.
- Asynchronous reset mid-load abandons the load. Memory keeps the words already written.

## Structure
- Shared package (`mem_loader_pkg`) holds:
  - the state encoding;
  - `HDR_BYTES`=8;
  - `WORD_BYTES`=4.
- No sub-module is required; the byte assembler is inline.
- Instantiated next to `memory` in the SoC top. Its outputs wire straight to `wr_mem_en`, `wr_mem_addr` and `wr_mem_data`.

## Test plan
- Header base=0x00000100, N=2, data bytes 11 22 33 44 55 66 77 88 sent back-to-back:
  - two writes: (0x100, 0x44332211) then (0x104, 0x88776655), each a one-cycle pulse;
  - `load_done` one cycle after the second write.
- Same stream with `s_valid` toggled every other cycle: identical writes and values, with stretched spacing.
- N=0: no `wr_mem_en`; `load_done` one cycle after header byte 8; `load_busy` pulse covers the header only.
- Base=0x00000103, N=1, data DE AD BE EF:
  - `load_err`=1;
  - write (0x100, 0xEFBEADDE).
- `load_abort` after 2 data bytes of N=1, then a fresh load base=0x200, N=1, data 01 02 03 04:
  - the aborted load produces no write;
  - the fresh load writes (0x200, 0x04030201).
- Base=0xFFFFFFFC, N=2: writes go to 0xFFFFFFFC then 0x00000000 (wrap-around).
- `ARESETn` pulsed low mid-word: all outputs return to their reset values immediately; the next full stream loads correctly.
